pen_servo_sequencer: RTL and testbench

//   Sequences the pen-lift servo of the plotter. Accepts pen up/down commands from the

---
 rtl/pen_servo_pkg.sv | 32 +++
 rtl/pen_servo_sequencer_if.sv | 20 ++
 rtl/servo_frame_timer.sv | 28 ++
 rtl/pen_servo_sequencer.sv | 120 ++++++++++++
 tb/tb_pen_servo_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pen_servo_pkg.sv
// rtl/pen_servo_pkg.sv - shared types, widths and default timing for the pen-lift servo sequencer
package pen_servo_pkg;

    localparam int WIDTH_BITS = 20;
    typedef logic [WIDTH_BITS-1:0] width_t;
    localparam width_t WIDTH_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        SETTLE
    } state_e;

    // Defaults also used by the processor MMIO decode
    localparam int DEF_SYS_FREQ      = 50_000_000;
    localparam int DEF_PULSE_FREQ    = 50;
    localparam int DEF_WIDTH_UP      = 50_000;
    localparam int DEF_WIDTH_DOWN    = 200_000;
    localparam int DEF_STEP          = 5_000;
    localparam int DEF_SETTLE_FRAMES = 10;

    // Move cur toward tgt by at most step, never passing tgt
    function automatic width_t slew_toward(width_t cur, width_t tgt, width_t step);
        width_t diff;
        diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        if (diff > step) begin
            diff = step;
        end
        return (tgt > cur) ? (cur + diff) : (cur - diff);
    endfunction

endpackage

// File: rtl/pen_servo_sequencer_if.sv
// rtl/pen_servo_sequencer_if.sv - pen up/down command handshake between MMIO path and sequencer
interface pen_servo_sequencer_if;

    logic cmd_valid;
    logic cmd_pen_down;
    logic cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_pen_down,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pen_down,
        output cmd_ready
    );

endinterface

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - servo frame counter with registered frame_start on wrap to 0
module servo_frame_timer #(
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int CNT_BITS     = $clog2(FRAME_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [CNT_BITS-1:0] frame_cnt,
    output logic                frame_last,
    output logic                frame_start
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(FRAME_CYCLES - 1);

    assign frame_last = (frame_cnt == LAST);

    // frame_start is registered so it lines up with frame_cnt == 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_cnt   <= frame_last ? '0 : (frame_cnt + CNT_BITS'(1));
            frame_start <= frame_last;
        end
    end

endmodule

// File: rtl/pen_servo_sequencer.sv
// rtl/pen_servo_sequencer.sv - pen-lift servo sequencer; PEN_SERVO_SEQ_RAMP_EN enables per-frame slew limiting
module pen_servo_sequencer
    import pen_servo_pkg::*;
#(
    parameter int SYS_FREQ      = DEF_SYS_FREQ,
    parameter int PULSE_FREQ    = DEF_PULSE_FREQ,
    parameter int WIDTH_UP      = DEF_WIDTH_UP,
    parameter int WIDTH_DOWN    = DEF_WIDTH_DOWN,
    parameter int STEP          = DEF_STEP,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
    input  logic                 clk,
    input  logic                 reset,
    pen_servo_sequencer_if.slave cmd,
    output logic                 busy,
    output logic                 done,
    output logic                 pen_is_down,
    output width_t               active_width,
    output logic                 frame_start,
    output logic                 pwm_out
);

    localparam int FRAME_CYCLES = SYS_FREQ / PULSE_FREQ;
    localparam int CNT_BITS     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam width_t W_UP     = width_t'(WIDTH_UP);
    localparam width_t W_DOWN   = width_t'(WIDTH_DOWN);
    localparam logic [15:0] SETTLE_N = 16'(SETTLE_FRAMES);

`ifdef PEN_SERVO_SEQ_RAMP_EN
    localparam width_t SLEW_STEP = (STEP < 1) ? width_t'(1) : width_t'(STEP);
`else
    // An unlimited step lands on the target in a single frame
    localparam width_t SLEW_STEP = width_t'(STEP) | WIDTH_MAX;
`endif

    logic [CNT_BITS-1:0] frame_cnt;
    logic                frame_last;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .CNT_BITS     (CNT_BITS)
    ) u_frame_timer (
        .clk         (clk),
        .reset       (reset),
        .frame_cnt   (frame_cnt),
        .frame_last  (frame_last),
        .frame_start (frame_start)
    );

    state_e      state;
    width_t      target;
    logic [15:0] settle_cnt;
    logic        cmd_ready;
    logic        accept;
    width_t      new_target;

    assign cmd.cmd_ready = cmd_ready;
    assign accept        = cmd.cmd_valid & cmd_ready;
    assign new_target    = cmd.cmd_pen_down ? W_DOWN : W_UP;

    // Width updates on the last cycle of a frame so each frame is emitted with one width;
    // cmd_ready stays low through the done cycle and rises the cycle after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= W_UP;
            active_width <= W_UP;
            settle_cnt   <= '0;
            pen_is_down  <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            done    <= 1'b0;
            pwm_out <= (32'(frame_cnt) < 32'(active_width));
            case (state)
                IDLE: begin
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (accept) begin
                        target      <= new_target;
                        pen_is_down <= cmd.cmd_pen_down;
                        cmd_ready   <= 1'b0;
                        if (new_target == active_width) begin
                            done <= 1'b1;
                        end else begin
                            state <= SLEW;
                            busy  <= 1'b1;
                        end
                    end
                end
                SLEW: begin
                    if (frame_last) begin
                        if (active_width == target) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            active_width <= slew_toward(active_width, target, SLEW_STEP);
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_N) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (frame_last) begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pen_servo_sequencer.sv
// tb/tb_pen_servo_sequencer.sv - self-checking bench for pen_servo_sequencer with frame-schedule model
module tb_pen_servo_sequencer;

    localparam int SYS_FREQ   = 1000;
    localparam int PULSE_FREQ = 10;
    localparam int FRAME      = SYS_FREQ / PULSE_FREQ;
    localparam int W_UP       = 10;
    localparam int W_DOWN     = 40;
    localparam int STEP       = 10;
    localparam int SETTLE     = 2;
`ifdef PEN_SERVO_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy, done, pen_is_down, frame_start, pwm_out;
    logic [19:0] active_width;

    pen_servo_sequencer_if cmd_if();

    pen_servo_sequencer #(
        .SYS_FREQ      (SYS_FREQ),
        .PULSE_FREQ    (PULSE_FREQ),
        .WIDTH_UP      (W_UP),
        .WIDTH_DOWN    (W_DOWN),
        .STEP          (STEP),
        .SETTLE_FRAMES (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd_if),
        .busy         (busy),
        .done         (done),
        .pen_is_down  (pen_is_down),
        .active_width (active_width),
        .frame_start  (frame_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Model: cycle index since reset release plus the schedule of the last accepted command
    int n        = 0;
    bit has_cmd  = 1'b0;
    int acc_cyc  = 0;
    int w0       = W_UP;
    int tgt      = W_UP;
    int moves    = 0;
    int done_cyc = 0;
    bit pd_old   = 1'b0;
    bit pd_new   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, n, act, exp);
    endtask

    // First frame boundary that can act on a command accepted in cycle a
    function automatic int first_boundary(int a);
        return ((a + 2 + FRAME - 1) / FRAME) * FRAME;
    endfunction

    function automatic int exp_width(int c);
        int k, d, mv, fb;
        if (!has_cmd) return W_UP;
        fb = first_boundary(acc_cyc);
        k  = (c >= fb) ? ((c - fb) / FRAME + 1) : 0;
        d  = (tgt > w0) ? (tgt - w0) : (w0 - tgt);
        mv = RAMP ? k * STEP : ((k > 0) ? d : 0);
        if (mv > d) mv = d;
        return (tgt > w0) ? (w0 + mv) : (w0 - mv);
    endfunction

    function automatic bit exp_pen(int c);
        return (has_cmd && c > acc_cyc) ? pd_new : pd_old;
    endfunction

    function automatic bit exp_busy(int c);
        return has_cmd && (tgt != w0) && (c > acc_cyc) && (c < done_cyc);
    endfunction

    function automatic bit exp_ready(int c);
        return !has_cmd || (c > done_cyc);
    endfunction

    always @(negedge clk) begin : compare
        int d;
        if (reset) begin
            n = 0; has_cmd = 1'b0; pd_old = 1'b0; pd_new = 1'b0; w0 = W_UP; tgt = W_UP;
        end else begin
            check("frame_start", int'(frame_start), int'(n > 0 && (n % FRAME) == 0));
            check("pwm_out", int'(pwm_out), int'(n > 0 && ((n - 1) % FRAME) < exp_width(n - 1)));
            check("active_width", int'(active_width), exp_width(n));
            check("busy", int'(busy), int'(exp_busy(n)));
            check("done", int'(done), int'(has_cmd && n == done_cyc));
            check("cmd_ready", int'(cmd_if.cmd_ready), int'(exp_ready(n)));
            check("pen_is_down", int'(pen_is_down), int'(exp_pen(n)));
            if (cmd_if.cmd_valid && exp_ready(n)) begin
                pd_old   = exp_pen(n);
                w0       = exp_width(n);
                pd_new   = cmd_if.cmd_pen_down;
                acc_cyc  = n;
                has_cmd  = 1'b1;
                tgt      = pd_new ? W_DOWN : W_UP;
                d        = (tgt > w0) ? (tgt - w0) : (w0 - tgt);
                moves    = RAMP ? (d + STEP - 1) / STEP : 1;
                done_cyc = (d == 0) ? n + 1 : first_boundary(n) + (moves + SETTLE) * FRAME + 1;
            end
            n++;
        end
    end

    int fs_w[3];

    task automatic wait_frame_start();
        bit found = 1'b0;
        for (int c = 0; c < 3 * FRAME && !found; c++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        check("frame_start_seen", int'(found), 1);
    endtask

    task automatic send_cmd(input bit pd);
        bit got = 1'b0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pen_down = pd;
        for (int c = 0; c < 20 * FRAME && !got; c++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("cmd_accepted", int'(got), 1);
    endtask

    task automatic wait_done(output int lat);
        int nfs = 0;
        lat = -1;
        for (int i = 0; i < 3; i++) fs_w[i] = -1;
        for (int c = 1; c <= 20 * FRAME && lat < 0; c++) begin
            @(negedge clk);
            if (frame_start && nfs < 3) begin
                fs_w[nfs] = int'(active_width);
                nfs++;
            end
            if (done) lat = c;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, hi, first_hi, fs, bad, gap;
        bit seen_done, acc;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pen_down = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_active_width", int'(active_width), 10);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_pen_is_down", int'(pen_is_down), 0);
        check("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle: 10-of-100 high, frame_start at cycle 100
        hi = 0; first_hi = -1; fs = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (pwm_out) begin
                hi++;
                if (first_hi < 0) first_hi = c;
            end
            if (frame_start) fs++;
        end
        check("idle_pwm_high_cycles", hi, 20);
        check("idle_first_high_cycle", first_hi, 1);
        check("idle_frame_starts", fs, 1);

        // Pen-up while already up
        send_cmd(1'b0);
        wait_done(lat);
        check("up_while_up_latency", lat, 1);
        check("up_while_up_width", int'(active_width), 10);

        // Pen-down accepted 10 cycles into a frame
        wait_frame_start();
        repeat (9) @(posedge clk);
        send_cmd(1'b1);
        wait_done(lat);
        check("down_width_frame1", fs_w[0], RAMP ? 20 : 40);
        check("down_width_frame2", fs_w[1], RAMP ? 30 : 40);
        check("down_width_frame3", fs_w[2], 40);
        check("down_latency", lat, RAMP ? 591 : 391);

        // Pen-down while already down, right after done
        send_cmd(1'b1);
        wait_done(lat);
        check("down_while_down_latency", lat, 1);

        // Command held during SLEW
        wait_frame_start();
        repeat (9) @(posedge clk);
        send_cmd(1'b0);
        repeat (50) @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pen_down = 1'b1;
        bad = 0; gap = -1; seen_done = 1'b0; acc = 1'b0;
        for (int c = 0; c < 20 * FRAME && !acc; c++) begin
            @(negedge clk);
            if (busy && cmd_if.cmd_ready) bad++;
            if (done) begin
                seen_done = 1'b1;
                gap = 0;
            end else if (seen_done) begin
                gap++;
            end
            if (seen_done && cmd_if.cmd_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("held_ready_while_busy", bad, 0);
        check("held_accept_after_done", gap, 1);
        wait_done(lat);
        check("held_cmd_latency", lat, RAMP ? 599 : 399);

        // Reset mid-SLEW going up from 40
        wait_frame_start();
        repeat (9) @(posedge clk);
        send_cmd(1'b0);
        wait_frame_start();
        check("mid_slew_width", int'(active_width), RAMP ? 30 : 10);
        check("mid_slew_busy", int'(busy), 1);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_active_width", int'(active_width), 10);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_pwm_out", int'(pwm_out), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2 * FRAME + 50) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
